tex_spi_reader: RTL and testbench

//  Texture fetch engine between the raybox-zero renderer and the external SPI flash texture ROM (W25Q128JV).
//  - Accepts one 24-bit byte address per request.
//  - Runs a single-bit SPI READ (0x03) or FAST READ (0x0B) transaction.
//  - Returns DATA_BITS bits, MSB first.
//  - Drives the tex_csb / tex_sclk / tex_io[0] pins and samples tex_io[1].

---
 rtl/tex_spi_pkg.sv | 23 ++
 rtl/spi_shift_phase.sv | 45 ++++
 rtl/tex_spi_reader.sv | 127 ++++++++++++
 tb/tb_tex_spi_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_spi_pkg.sv
// rtl/tex_spi_pkg.sv - shared types and constants for the SPI flash texture reader
package tex_spi_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_CSH
    } state_t;

    // Per-state bit counts are held in a 6-bit down counter.
    function automatic logic [5:0] bit_count(input int n);
        return n[5:0];
    endfunction

endpackage

// File: rtl/spi_shift_phase.sv
// rtl/spi_shift_phase.sv - 32-bit shift register, bit counter and SCLK phase toggle
module spi_shift_phase (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        cnt_load,
    input  logic [5:0]  cnt_val,
    input  logic        enable,
    input  logic        shift_in,
    output logic        phase,
    output logic [31:0] shreg,
    output logic        bit_done,
    output logic        last_bit
);

    logic [5:0] cnt;

    // A bit ends on its phase1 cycle; the counter reaching 1 marks the last bit of a state.
    assign bit_done = enable & phase;
    assign last_bit = (cnt == 6'd1);

    // Phase toggles only while the bus is active so SCLK rests low between transactions;
    // the register shifts out MSB first and pulls MISO into the LSB at each bit end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            shreg <= 32'd0;
            cnt   <= 6'd0;
        end else begin
            phase <= enable ? ~phase : 1'b0;
            if (load) begin
                shreg <= load_word;
            end else if (bit_done) begin
                shreg <= {shreg[30:0], shift_in};
            end
            if (cnt_load) begin
                cnt <= cnt_val;
            end else if (bit_done) begin
                cnt <= cnt - 6'd1;
            end
        end
    end

endmodule

// File: rtl/tex_spi_reader.sv
// rtl/tex_spi_reader.sv - single-bit SPI READ / FAST READ texture fetch engine
module tex_spi_reader
    import tex_spi_pkg::*;
#(
    parameter logic [7:0] CMD        = CMD_READ,
    parameter int         DUMMY_BITS = 0,
    parameter int         DATA_BITS  = 8,
    parameter int         CSH_CYCLES = 2   // minimum 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 tex_csb,
    output logic                 tex_sclk,
    output logic                 tex_out0,
    output logic                 tex_oe0,
    input  logic                 tex_in1
);

    localparam logic [5:0] CMD_CNT   = bit_count(8);
    localparam logic [5:0] ADDR_CNT  = bit_count(ADDR_W);
    localparam logic [5:0] DUMMY_CNT = bit_count(DUMMY_BITS);
    localparam logic [5:0] DATA_CNT  = bit_count(DATA_BITS);
    localparam logic [7:0] CSH_LOAD  = 8'(CSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic        sh_load, cnt_load, enable;
    logic [5:0]  cnt_val;
    logic        phase, bit_done, last_bit;
    logic [31:0] shreg, sample_word;
    logic [7:0]  csh_cnt;
    logic        state_end;

    assign enable      = (state == ST_CMD) || (state == ST_ADDR) ||
                         (state == ST_DUMMY) || (state == ST_DATA);
    assign state_end   = bit_done & last_bit;
    assign sample_word = {shreg[30:0], tex_in1};

    assign req_ready = (state == ST_IDLE);
    assign tex_csb   = ~enable;
    assign tex_sclk  = phase;
    assign tex_oe0   = (state == ST_CMD) || (state == ST_ADDR);
    assign tex_out0  = tex_oe0 & shreg[31];

    spi_shift_phase u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_word ({CMD, req_addr}),
        .cnt_load  (cnt_load),
        .cnt_val   (cnt_val),
        .enable    (enable),
        .shift_in  (tex_in1),
        .phase     (phase),
        .shreg     (shreg),
        .bit_done  (bit_done),
        .last_bit  (last_bit)
    );

    // Next state plus the counter reload that accompanies every state entry.
    always_comb begin
        state_nxt = state;
        sh_load   = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = 6'd0;
        case (state)
            ST_IDLE: if (req_valid) begin
                state_nxt = ST_CMD;
                sh_load   = 1'b1;
                cnt_load  = 1'b1;
                cnt_val   = CMD_CNT;
            end
            ST_CMD: if (state_end) begin
                state_nxt = ST_ADDR;
                cnt_load  = 1'b1;
                cnt_val   = ADDR_CNT;
            end
            ST_ADDR: if (state_end) begin
                cnt_load = 1'b1;
                if (DUMMY_BITS > 0) begin
                    state_nxt = ST_DUMMY;
                    cnt_val   = DUMMY_CNT;
                end else begin
                    state_nxt = ST_DATA;
                    cnt_val   = DATA_CNT;
                end
            end
            ST_DUMMY: if (state_end) begin
                state_nxt = ST_DATA;
                cnt_load  = 1'b1;
                cnt_val   = DATA_CNT;
            end
            ST_DATA: if (state_end) begin
                state_nxt = ST_CSH;
            end
            ST_CSH: if (csh_cnt == 8'd0) begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, CS-high hold counter and the one-cycle response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            csh_cnt   <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            if (state == ST_DATA && state_end) begin
                rsp_valid <= 1'b1;
                rsp_data  <= sample_word[DATA_BITS-1:0];
                csh_cnt   <= CSH_LOAD;
            end else if (state == ST_CSH && csh_cnt != 8'd0) begin
                csh_cnt <= csh_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tex_spi_reader.sv
// tb/tb_tex_spi_reader.sv - directed bench with a behavioural SPI flash model
module tb_tex_spi_reader;
    import tex_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic        io1 = 1'b0;

    logic        req_ready_a, rsp_valid_a, csb_a, sclk_a, out0_a, oe0_a;
    logic [7:0]  rsp_data_a;
    logic        req_ready_b, rsp_valid_b, csb_b, sclk_b, out0_b, oe0_b;
    logic [15:0] rsp_data_b;

    logic        m_csb, m_sclk, m_out0, m_oe, m_rsp_valid, m_req_ready;
    logic [31:0] m_rsp_data;
    int          m_dummy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tex_spi_reader u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
        .req_addr(req_addr), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
        .tex_csb(csb_a), .tex_sclk(sclk_a), .tex_out0(out0_a), .tex_oe0(oe0_a), .tex_in1(io1)
    );

    tex_spi_reader #(.CMD(CMD_FAST_READ), .DUMMY_BITS(8), .DATA_BITS(16), .CSH_CYCLES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(req_ready_b),
        .req_addr(req_addr), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .tex_csb(csb_b), .tex_sclk(sclk_b), .tex_out0(out0_b), .tex_oe0(oe0_b), .tex_in1(io1)
    );

    assign m_csb       = sel ? csb_b : csb_a;
    assign m_sclk      = sel ? sclk_b : sclk_a;
    assign m_out0      = sel ? out0_b : out0_a;
    assign m_oe        = sel ? oe0_b : oe0_a;
    assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_req_ready = sel ? req_ready_b : req_ready_a;
    assign m_rsp_data  = sel ? {16'd0, rsp_data_b} : {24'd0, rsp_data_a};
    assign m_dummy     = sel ? 8 : 0;

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'hFFFFFF: return 8'h3C;
            24'h000100: return 8'h5A;
            24'h000200: return 8'hC3;
            24'h000020: return 8'h12;
            24'h000021: return 8'h34;
            24'h000030: return 8'h77;
            default:    return a[7:0] ^ 8'h96;
        endcase
    endfunction

    // Flash model: counts SCLK rises, captures the first 32 MOSI bits, snapshots both on CS rise.
    int          bitn = 0;
    logic [31:0] mosi = 32'd0;
    int          last_edges = 0;
    logic [31:0] last_mosi = 32'd0;
    always @(posedge m_sclk or posedge m_csb) begin
        if (m_csb === 1'b1) begin
            last_edges = bitn;
            last_mosi  = mosi;
            bitn       = 0;
            mosi       = 32'd0;
        end else if (m_csb === 1'b0) begin
            if (bitn < 32) mosi = {mosi[30:0], m_out0};
            bitn++;
        end
    end

    // Mode 0 read data: next bit driven on each SCLK fall once command, address and dummy are in.
    int         k;
    logic [7:0] rb;
    always @(negedge m_sclk) begin
        if (m_csb === 1'b0 && bitn >= 32 + m_dummy) begin
            k   = bitn - 32 - m_dummy;
            rb  = rom_byte(mosi[23:0] + 24'(k / 8));
            io1 = rb[7 - (k % 8)];
        end
    end

    // io0 must be driven through command/address and released from the first dummy/data phase0.
    int oe_viol = 0;
    always @(negedge clk) begin
        if (m_csb === 1'b0) begin
            if ((bitn < 32 || (bitn == 32 && m_sclk === 1'b1)) && m_oe !== 1'b1) oe_viol++;
            if ((bitn > 32 || (bitn == 32 && m_sclk === 1'b0)) && m_oe !== 1'b0) oe_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic c1_csb, c1_rdy;

    task automatic run_req(input logic [23:0] a, input int pulse_cyc, input logic [23:0] pulse_a,
                           output int lat, output logic [31:0] d);
        lat = 0;
        d   = 32'd0;
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = (c == pulse_cyc);
            if (c == pulse_cyc) req_addr = pulse_a;
            else if (c == 1) req_addr = ~a;
            if (c == 1) begin
                c1_csb = m_csb;
                c1_rdy = m_req_ready;
            end
            if (m_rsp_valid === 1'b1) begin
                lat = c;
                d   = m_rsp_data;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic check_tail();
        check("csb_after_rsp", {31'd0, m_csb}, 32'd1);
        check("sclk_after_rsp", {31'd0, m_sclk}, 32'd0);
        @(negedge clk);
        check("ready_in_csh", {31'd0, m_req_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_csh", {31'd0, m_req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, r1c, r2c, acc2, nrsp;
        logic [31:0] d, r1d, r2d;
        logic        csb81, csb82, csb_acc;

        r1c = 0; r2c = 0; acc2 = 0; nrsp = 0;
        r1d = 0; r2d = 0; csb81 = 0; csb82 = 0; csb_acc = 1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_csb", {31'd0, m_csb}, 32'd1);
        check("rst_sclk", {31'd0, m_sclk}, 32'd0);
        check("rst_oe0", {31'd0, m_oe}, 32'd0);
        check("rst_out0", {31'd0, m_out0}, 32'd0);
        check("rst_ready", {31'd0, m_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        check("rst_rsp_data", m_rsp_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Default read of 0x000010
        run_req(24'h000010, 0, 24'h0, lat, d);
        check("t2_latency", lat, 32'd81);
        check("t2_data", d, 32'h000000A5);
        check("t2_csb_cycle1", {31'd0, c1_csb}, 32'd0);
        check("t2_ready_cycle1", {31'd0, c1_rdy}, 32'd0);
        check("t2_sclk_edges", last_edges, 32'd40);
        check("t2_mosi", last_mosi, 32'h03000010);
        check_tail();

        // Reset at cycle 60 aborts the transaction
        @(negedge clk);
        req_addr  = 24'h000100;
        req_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("t1_csb", {31'd0, m_csb}, 32'd1);
        check("t1_sclk", {31'd0, m_sclk}, 32'd0);
        check("t1_oe0", {31'd0, m_oe}, 32'd0);
        check("t1_ready", {31'd0, m_req_ready}, 32'd1);
        check("t1_rsp_data_cleared", m_rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_rsp_valid === 1'b1) nrsp++;
        end
        check("t1_no_rsp", nrsp, 32'd0);
        run_req(24'h000010, 0, 24'h0, lat, d);
        check("t1_post_latency", lat, 32'd81);
        check("t1_post_data", d, 32'h000000A5);
        check_tail();

        // Top address
        run_req(24'hFFFFFF, 0, 24'h0, lat, d);
        check("t3_latency", lat, 32'd81);
        check("t3_data", d, 32'h0000003C);
        check("t3_mosi", last_mosi, 32'h03FFFFFF);
        check_tail();

        // Request pulsed during DATA is ignored
        run_req(24'h000010, 70, 24'h000030, lat, d);
        check("t6_latency", lat, 32'd81);
        check("t6_data", d, 32'h000000A5);
        check("t6_mosi", last_mosi, 32'h03000010);
        check_tail();

        // Back-to-back with req_valid held
        @(negedge clk);
        req_addr  = 24'h000100;
        req_valid = 1'b1;
        for (int c = 1; c <= 400 && r2c == 0; c++) begin
            @(negedge clk);
            if (c == 1) req_addr = 24'h000200;
            if (c == 81) csb81 = m_csb;
            if (c == 82) csb82 = m_csb;
            if (acc2 != 0 && c == acc2 + 1) begin
                csb_acc   = m_csb;
                req_valid = 1'b0;
            end
            if (m_rsp_valid === 1'b1) begin
                if (r1c == 0) begin
                    r1c = c;
                    r1d = m_rsp_data;
                end else begin
                    r2c = c;
                    r2d = m_rsp_data;
                end
            end
            if (acc2 == 0 && c > 1 && m_req_ready === 1'b1) acc2 = c;
        end
        req_valid = 1'b0;
        check("t4_first_latency", r1c, 32'd81);
        check("t4_first_data", r1d, 32'h0000005A);
        check("t4_csb_81", {31'd0, csb81}, 32'd1);
        check("t4_csb_82", {31'd0, csb82}, 32'd1);
        check("t4_second_accept", acc2, 32'd83);
        check("t4_csb_falls", {31'd0, csb_acc}, 32'd0);
        check("t4_second_latency", r2c, 32'd164);
        check("t4_second_data", r2d, 32'h000000C3);
        check_tail();

        // FAST READ with dummy cycles and 16-bit data
        sel = 1'b1;
        @(negedge clk);
        run_req(24'h000020, 0, 24'h0, lat, d);
        check("t5_latency", lat, 32'd113);
        check("t5_data", d, 32'h00001234);
        check("t5_sclk_edges", last_edges, 32'd56);
        check("t5_mosi", last_mosi, 32'h0B000020);
        check_tail();

        check("oe0_windows", oe_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
